// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 round controller.
// Contents:
//   aes_state_e   - controller FSM states
//   AES128_ROUNDS - number of rounds for AES-128
//   ROUND_W       - width of the round index bus (dp_round)
//   RCON_INIT     - first key-expansion round constant
//   xtime()       - multiply-by-x in GF(2^8), used to step the round constant
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        STEP = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } aes_state_e;

    localparam int AES128_ROUNDS = 10;
    localparam int ROUND_W       = 4;

    localparam logic [7:0] RCON_INIT = 8'h01;

    // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Key-expansion round-constant register.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset, loads RCON_INIT
//   init_i    - reload RCON_INIT (start of a job or abort)
//   advance_i - step the constant to the next round (xtime)
//   rcon_o    - current round constant
// init_i wins over advance_i.
module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       init_i,
    input  logic       advance_i,
    output logic [7:0] rcon_o
);

    logic [7:0] rcon_q;
    logic [7:0] rcon_d;

    // Next round constant: reload, step, or hold.
    always_comb begin
        rcon_d = rcon_q;
        if (init_i) begin
            rcon_d = RCON_INIT;
        end else if (advance_i) begin
            rcon_d = xtime(rcon_q);
        end else begin
            rcon_d = rcon_q;
        end
    end

    // Round-constant register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcon_q <= RCON_INIT;
        end else begin
            rcon_q <= rcon_d;
        end
    end

    assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer. Accepts one job at a time and
// steps the shared round datapath through the initial key addition and
// ROUNDS rounds, then presents the result until the consumer takes it.
// Parameters:
//   ROUNDS - number of rounds (last one skips mix-columns)
//   DP_LAT - registered latency of one datapath round, >= 1
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - job request handshake (key/plaintext on datapath bus)
//   out_valid/out_ready - result handshake (ciphertext in datapath state reg)
//   flush               - synchronous abort, back to IDLE next cycle
//   dp_load             - datapath captures plaintext^key and key
//   dp_step             - datapath starts one round
//   dp_final            - qualifies dp_step: skip mix-columns
//   dp_round            - round index 1..ROUNDS while dp_step, else 0
//   rcon                - key-expansion round constant for the current round
//   busy                - controller not IDLE
// Every output is decoded from registers only; in_valid and out_ready
// reach the outputs only through the state register.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int ROUNDS = AES128_ROUNDS,
    parameter int DP_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               flush,
    output logic               dp_load,
    output logic               dp_step,
    output logic               dp_final,
    output logic [ROUND_W-1:0] dp_round,
    output logic [7:0]         rcon,
    output logic               busy
);

    // The wait counter only has to reach DP_LAT-1.
    localparam int WAIT_W = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

    localparam logic [WAIT_W-1:0]  WAIT_ZERO   = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0]  WAIT_ONE    = WAIT_W'(1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST   = WAIT_W'(DP_LAT - 1);
    localparam logic [ROUND_W-1:0] ROUND_ZERO  = {ROUND_W{1'b0}};
    localparam logic [ROUND_W-1:0] ROUND_ONE   = ROUND_W'(1);
    localparam logic [ROUND_W-1:0] ROUND_LAST  = ROUND_W'(ROUNDS);

    aes_state_e         state_q;
    aes_state_e         state_d;
    logic [ROUND_W-1:0] round_q;
    logic [ROUND_W-1:0] round_d;
    logic [WAIT_W-1:0]  wait_q;
    logic [WAIT_W-1:0]  wait_d;

    logic               rcon_init_s;
    logic               rcon_adv_s;

    // Outcome of finishing a round, shared by STEP (DP_LAT==1) and WAIT.
    aes_state_e         adv_state_s;
    logic [ROUND_W-1:0] adv_round_s;
    logic               adv_rcon_s;

    aes_rcon_gen u_rcon_gen (
        .clk       (clk),
        .rst       (rst),
        .init_i    (rcon_init_s),
        .advance_i (rcon_adv_s),
        .rcon_o    (rcon)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Round index and datapath-latency wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_q <= ROUND_ZERO;
            wait_q  <= WAIT_ZERO;
        end else begin
            round_q <= round_d;
            wait_q  <= wait_d;
        end
    end

    // Round-completion decision: either the last round finished or advance.
    always_comb begin
        adv_state_s = STEP;
        adv_round_s = round_q;
        adv_rcon_s  = 1'b0;
        if (round_q == ROUND_LAST) begin
            adv_state_s = DONE;
            adv_round_s = round_q;
            adv_rcon_s  = 1'b0;
        end else begin
            adv_state_s = STEP;
            adv_round_s = round_q + ROUND_ONE;
            adv_rcon_s  = 1'b1;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        wait_d      = wait_q;
        rcon_init_s = 1'b0;
        rcon_adv_s  = 1'b0;
        if (flush) begin
            // Reloading rcon here keeps every output at its reset value in IDLE.
            state_d     = IDLE;
            round_d     = ROUND_ZERO;
            wait_d      = WAIT_ZERO;
            rcon_init_s = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LOAD: begin
                    state_d     = STEP;
                    round_d     = ROUND_ONE;
                    wait_d      = WAIT_ZERO;
                    rcon_init_s = 1'b1;
                end
                STEP: begin
                    if (DP_LAT == 1) begin
                        state_d    = adv_state_s;
                        round_d    = adv_round_s;
                        rcon_adv_s = adv_rcon_s;
                    end else begin
                        state_d = WAIT;
                        wait_d  = WAIT_ONE;
                    end
                end
                WAIT: begin
                    if (wait_q == WAIT_LAST) begin
                        state_d    = adv_state_s;
                        round_d    = adv_round_s;
                        rcon_adv_s = adv_rcon_s;
                    end else begin
                        wait_d = wait_q + WAIT_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output decode from the state and round registers.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        dp_load   = 1'b0;
        dp_step   = 1'b0;
        dp_final  = 1'b0;
        dp_round  = ROUND_ZERO;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            LOAD: begin
                dp_load = 1'b1;
            end
            STEP: begin
                dp_step  = 1'b1;
                dp_final = (round_q == ROUND_LAST);
                dp_round = round_q;
            end
            WAIT: begin
                busy = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: one instance with default latency and one with
// DP_LAT=3. Expected strobes come from the timeline arithmetic
// (step r at cycle 2+(r-1)*L, result at 2+R*L); a behavioural AES datapath
// driven by the controller strobes produces the ciphertext.
module tb_aes_round_ctrl;

    localparam int ROUNDS = 10;
    localparam logic [17:0] IDLE_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h01};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic flush = 1'b0;
    logic sel3 = 1'b0;
    logic iv1, iv3;

    logic a_in_ready, a_out_valid, a_dp_load, a_dp_step, a_dp_final, a_busy;
    logic [3:0] a_dp_round;
    logic [7:0] a_rcon;
    logic b_in_ready, b_out_valid, b_dp_load, b_dp_step, b_dp_final, b_busy;
    logic [3:0] b_dp_round;
    logic [7:0] b_rcon;

    logic m_in_ready, m_out_valid, m_dp_load, m_dp_step, m_dp_final, m_busy;
    logic [3:0] m_dp_round;
    logic [7:0] m_rcon;
    logic [17:0] m_vec, a_vec, b_vec;

    int checks = 0;
    int errors = 0;
    logic [7:0] rcon_tab [10];

    logic [127:0] m_key, m_pt, st, rk;

    always #5 clk = ~clk;

    assign iv1 = in_valid & ~sel3;
    assign iv3 = in_valid & sel3;

    aes_round_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_ready(out_ready), .flush(flush),
        .dp_load(a_dp_load), .dp_step(a_dp_step), .dp_final(a_dp_final),
        .dp_round(a_dp_round), .rcon(a_rcon), .busy(a_busy)
    );

    aes_round_ctrl #(.ROUNDS(10), .DP_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_ready(out_ready), .flush(flush),
        .dp_load(b_dp_load), .dp_step(b_dp_step), .dp_final(b_dp_final),
        .dp_round(b_dp_round), .rcon(b_rcon), .busy(b_busy)
    );

    assign m_in_ready  = sel3 ? b_in_ready  : a_in_ready;
    assign m_out_valid = sel3 ? b_out_valid : a_out_valid;
    assign m_dp_load   = sel3 ? b_dp_load   : a_dp_load;
    assign m_dp_step   = sel3 ? b_dp_step   : a_dp_step;
    assign m_dp_final  = sel3 ? b_dp_final  : a_dp_final;
    assign m_dp_round  = sel3 ? b_dp_round  : a_dp_round;
    assign m_rcon      = sel3 ? b_rcon      : a_rcon;
    assign m_busy      = sel3 ? b_busy      : a_busy;
    assign m_vec = {m_in_ready, m_busy, m_out_valid, m_dp_load, m_dp_step, m_dp_final, m_dp_round, m_rcon};
    assign a_vec = {a_in_ready, a_busy, a_out_valid, a_dp_load, a_dp_step, a_dp_final, a_dp_round, a_rcon};
    assign b_vec = {b_in_ready, b_busy, b_out_valid, b_dp_load, b_dp_step, b_dp_final, b_dp_round, b_rcon};

    // ---------------- behavioural AES primitives ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t = {w3[23:0], w3[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h000000};
        w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [7:0] b [16];
        logic [7:0] n [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) n[r+4*c] = b[r+4*((c+r)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = n[4*c]; a1 = n[4*c+1]; a2 = n[4*c+2]; a3 = n[4*c+3];
                n[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
                n[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
                n[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
                n[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = n[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [127:0] k, s;
        logic [7:0] rc;
        k = key; s = pt ^ key; rc = 8'h01;
        for (int r = 1; r <= ROUNDS; r++) begin
            k = key_next(k, rc);
            s = round_fn(s, k, r == ROUNDS);
            rc = gmul(rc, 8'h02);
        end
        return s;
    endfunction

    // Datapath model driven by the selected controller's strobes (mid-cycle).
    always @(negedge clk) begin
        if (m_dp_load) begin
            st <= m_pt ^ m_key;
            rk <= m_key;
        end else if (m_dp_step) begin
            st <= round_fn(st, key_next(rk, m_rcon), m_dp_final);
            rk <= key_next(rk, m_rcon);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; sel3 = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (a_vec !== IDLE_VEC) begin errors++; $display("FAIL reset_held got %h want %h", a_vec, IDLE_VEC); end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (a_vec !== IDLE_VEC) begin errors++; $display("FAIL reset_idle_a cyc %0d got %h want %h", i, a_vec, IDLE_VEC); end
            checks++; if (b_vec !== IDLE_VEC) begin errors++; $display("FAIL reset_idle_b cyc %0d got %h want %h", i, b_vec, IDLE_VEC); end
        end
    endtask

    // One job on the selected instance; hold = DONE cycles with out_ready low,
    // noise = random in_valid pulses while busy.
    task automatic test_job(input bit use3, input int hold, input bit noise);
        int lat, done_c, rnd;
        bit es;
        logic [3:0] er;
        lat = use3 ? 3 : 1;
        done_c = 2 + ROUNDS * lat;
        sel3 = use3;
        out_ready = (hold == 0);
        checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL job_start_ready lat %0d got %b want 1", lat, m_in_ready); end
        in_valid = 1'b1;
        tick();
        for (int c = 1; c <= done_c + hold + 1; c++) begin
            es = (c >= 2) && (c < done_c) && ((c - 2) % lat == 0);
            rnd = es ? (c - 2) / lat + 1 : 0;
            er = 4'(rnd);
            in_valid = (noise && c < done_c) ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready = (c >= done_c + hold);
            checks++; if (m_dp_load !== (c == 1)) begin errors++; $display("FAIL job_load lat %0d cyc %0d got %b want %b", lat, c, m_dp_load, c == 1); end
            checks++; if (m_dp_step !== es) begin errors++; $display("FAIL job_step lat %0d cyc %0d got %b want %b", lat, c, m_dp_step, es); end
            checks++; if (m_dp_round !== er) begin errors++; $display("FAIL job_round lat %0d cyc %0d got %0d want %0d", lat, c, m_dp_round, er); end
            checks++; if (m_dp_final !== (es && rnd == ROUNDS)) begin errors++; $display("FAIL job_final lat %0d cyc %0d got %b want %b", lat, c, m_dp_final, es && rnd == ROUNDS); end
            if (es) begin
                checks++; if (m_rcon !== rcon_tab[rnd-1]) begin errors++; $display("FAIL job_rcon lat %0d round %0d got %h want %h", lat, rnd, m_rcon, rcon_tab[rnd-1]); end
            end
            checks++; if (m_out_valid !== (c >= done_c && c <= done_c + hold)) begin errors++; $display("FAIL job_out_valid lat %0d cyc %0d got %b", lat, c, m_out_valid); end
            checks++; if (m_in_ready !== (c > done_c + hold)) begin errors++; $display("FAIL job_in_ready lat %0d cyc %0d got %b", lat, c, m_in_ready); end
            checks++; if (m_busy !== (c <= done_c + hold)) begin errors++; $display("FAIL job_busy lat %0d cyc %0d got %b", lat, c, m_busy); end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_flush(input int fr);
        sel3 = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c < 2 + (fr - 1); c++) tick();
        checks++; if (m_dp_step !== 1'b1 || m_dp_round !== 4'(fr)) begin errors++; $display("FAIL flush_pre step %b round %0d want 1 %0d", m_dp_step, m_dp_round, fr); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (m_vec !== IDLE_VEC) begin errors++; $display("FAIL flush_idle got %h want %h", m_vec, IDLE_VEC); end
        tick();
        checks++; if (m_vec !== IDLE_VEC) begin errors++; $display("FAIL flush_stay got %h want %h", m_vec, IDLE_VEC); end
        flush = 1'b1; in_valid = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (m_vec !== IDLE_VEC) begin errors++; $display("FAIL flush_reject got %h want %h", m_vec, IDLE_VEC); end
        tick();
        checks++; if (m_vec !== IDLE_VEC) begin errors++; $display("FAIL flush_reject2 got %h want %h", m_vec, IDLE_VEC); end
        test_job(1'b0, 0, 1'b0);
    endtask

    task automatic test_async_reset();
        int wr, target;
        wr = $urandom_range(1, 9);
        target = 2 + (wr - 1) * 3 + 1 + $urandom_range(0, 1);
        sel3 = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c < target; c++) tick();
        checks++; if (m_busy !== 1'b1 || m_dp_step !== 1'b0 || m_dp_load !== 1'b0) begin errors++; $display("FAIL rst_pre_wait busy %b step %b load %b", m_busy, m_dp_step, m_dp_load); end
        #1 rst = 1'b1;
        #1;
        checks++; if (m_vec !== IDLE_VEC) begin errors++; $display("FAIL rst_async got %h want %h", m_vec, IDLE_VEC); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++; if (m_vec !== IDLE_VEC) begin errors++; $display("FAIL rst_release got %h want %h", m_vec, IDLE_VEC); end
        test_job(1'b1, 0, 1'b0);
    endtask

    task automatic test_cipher();
        logic [127:0] want;
        want = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        m_key = 128'h000102030405060708090a0b0c0d0e0f;
        m_pt  = 128'h00112233445566778899aabbccddeeff;
        checks++; if (aes_ref(m_key, m_pt) !== want) begin errors++; $display("FAIL cipher_refmodel got %h want %h", aes_ref(m_key, m_pt), want); end
        test_job(1'b0, 0, 1'b0);
        checks++; if (st !== want) begin errors++; $display("FAIL cipher_fips got %h want %h", st, want); end
        m_key = {$urandom(), $urandom(), $urandom(), $urandom()};
        m_pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
        test_job(1'b1, $urandom_range(0, 3), 1'b1);
        checks++; if (st !== aes_ref(m_key, m_pt)) begin errors++; $display("FAIL cipher_random got %h want %h", st, aes_ref(m_key, m_pt)); end
    endtask

    task automatic test_back_to_back();
        int loads[$];
        int t;
        sel3 = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        t = 0;
        while (loads.size() < 2 && t < 40) begin
            tick();
            t++;
            if (m_dp_load === 1'b1) loads.push_back(t);
        end
        in_valid = 1'b0;
        checks++;
        if (loads.size() != 2) begin
            errors++; $display("FAIL b2b_loads got %0d want 2", loads.size());
        end else if (loads[1] - loads[0] != 13) begin
            errors++; $display("FAIL b2b_period got %0d want 13", loads[1] - loads[0]);
        end
        t = 0;
        while (m_in_ready !== 1'b1 && t < 60) begin
            tick();
            t++;
        end
        checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_drain got %b want 1", m_in_ready); end
    endtask

    initial begin
        rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        m_key = 128'h0;
        m_pt  = 128'h0;
        test_reset();
        test_job(1'b0, 0, 1'b0);
        test_job(1'b1, 0, 1'b1);
        test_job(1'b0, 7, 1'b0);
        test_job(1'b1, $urandom_range(1, 5), 1'b1);
        test_flush(5);
        test_flush($urandom_range(1, 10));
        test_async_reset();
        test_cipher();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
